// File: rtl/osg_cfg_pkg.sv
// Shared constants, state encoding and address helpers for the channel-configuration bank.
package osg_cfg_pkg;

    localparam int BYTES_PER_CH = 7;

    // Byte offsets within one channel's 7-byte window
    localparam logic [2:0] OFF_PL_H    = 3'd0;
    localparam logic [2:0] OFF_PL_L    = 3'd1;
    localparam logic [2:0] OFF_MULT_PL = 3'd2;
    localparam logic [2:0] OFF_DL_H    = 3'd3;
    localparam logic [2:0] OFF_DL_L    = 3'd4;
    localparam logic [2:0] OFF_MULT_DL = 3'd5;
    localparam logic [2:0] OFF_TYPE    = 3'd6;

    localparam logic [7:0] CMD_APPLY_START = 8'hFF;
    localparam logic [7:0] CMD_APPLY       = 8'hA5;
    localparam logic [7:0] CMD_CLR_ERR     = 8'h5A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        START = 2'd2
    } cfg_state_t;

    // First byte address of channel ch; address 0 is the command register.
    function automatic logic [8:0] ch_base(input int ch);
        return 9'(1 + BYTES_PER_CH * ch);
    endfunction

endpackage

// File: rtl/chan_cfg_slot.sv
// One channel's shadow and active configuration registers, with local decode of
// its 7-byte address window for writes and readback.
module chan_cfg_slot
    import osg_cfg_pkg::*;
#(
    parameter int CH     = 0,
    parameter int MULT_W = 5,
    parameter int TYPE_W = 4
) (
    input  logic              clk_RAM,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [7:0]        rd_addr,
    input  logic              apply,
    output logic [7:0]        rd_byte,
    output logic [15:0]       pl_drt,
    output logic [15:0]       dl_del,
    output logic [MULT_W-1:0] mult_pl,
    output logic [MULT_W-1:0] mult_dl,
    output logic [TYPE_W-1:0] type_start
);

    localparam logic [8:0] BASE = ch_base(CH);

    logic [8:0]        wr_off;
    logic [8:0]        rd_off;
    logic              wr_hit;
    logic              rd_hit;
    logic [15:0]       sh_pl;
    logic [15:0]       sh_dl;
    logic [MULT_W-1:0] sh_mpl;
    logic [MULT_W-1:0] sh_mdl;
    logic [TYPE_W-1:0] sh_type;

    // Addresses below BASE wrap to large offsets, so a single compare bounds the window.
    assign wr_off = {1'b0, wr_addr} - BASE;
    assign rd_off = {1'b0, rd_addr} - BASE;
    assign wr_hit = wr_en && (wr_off < 9'(BYTES_PER_CH));
    assign rd_hit = rd_off < 9'(BYTES_PER_CH);

    // NOTE: every field is a plain flop on the async reset, so the bank reads back 0 with no init pass.
    always_ff @(posedge clk_RAM or negedge rst_n) begin
        if (!rst_n) begin
            sh_pl   <= '0;
            sh_dl   <= '0;
            sh_mpl  <= '0;
            sh_mdl  <= '0;
            sh_type <= '0;
        end else if (wr_hit) begin
            case (wr_off[2:0])
                OFF_PL_H:    sh_pl[15:8] <= wr_data;
                OFF_PL_L:    sh_pl[7:0]  <= wr_data;
                OFF_MULT_PL: sh_mpl      <= wr_data[MULT_W-1:0];
                OFF_DL_H:    sh_dl[15:8] <= wr_data;
                OFF_DL_L:    sh_dl[7:0]  <= wr_data;
                OFF_MULT_DL: sh_mdl      <= wr_data[MULT_W-1:0];
                OFF_TYPE:    sh_type     <= wr_data[TYPE_W-1:0];
                default:     ;
            endcase
        end
    end

    // NOTE: non-blocking assignment makes a shadow write on the apply edge miss this copy.
    always_ff @(posedge clk_RAM or negedge rst_n) begin
        if (!rst_n) begin
            pl_drt     <= '0;
            dl_del     <= '0;
            mult_pl    <= '0;
            mult_dl    <= '0;
            type_start <= '0;
        end else if (apply) begin
            pl_drt     <= sh_pl;
            dl_del     <= sh_dl;
            mult_pl    <= sh_mpl;
            mult_dl    <= sh_mdl;
            type_start <= sh_type;
        end
    end

    always_comb begin
        // NOTE: default first so the partial decode below cannot infer a latch.
        rd_byte = '0;
        if (rd_hit) begin
            case (rd_off[2:0])
                OFF_PL_H:    rd_byte = sh_pl[15:8];
                OFF_PL_L:    rd_byte = sh_pl[7:0];
                OFF_MULT_PL: rd_byte = 8'(sh_mpl);
                OFF_DL_H:    rd_byte = sh_dl[15:8];
                OFF_DL_L:    rd_byte = sh_dl[7:0];
                OFF_MULT_DL: rd_byte = 8'(sh_mdl);
                OFF_TYPE:    rd_byte = 8'(sh_type);
                default:     rd_byte = '0;
            endcase
        end
    end

endmodule

// File: rtl/chan_cfg_bank.sv
// Channel-configuration register bank: shadow/active slots per channel, command
// decode, apply/start sequencing, readback mux and sticky error flags.
module chan_cfg_bank
    import osg_cfg_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int MULT_W = 5,
    parameter int TYPE_W = 4
) (
    input  logic                     clk_RAM,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [7:0]               rd_addr,
    output logic [7:0]               rd_data,
    output logic [NUM_CH*16-1:0]     pl_drt,
    output logic [NUM_CH*16-1:0]     dl_del,
    output logic [NUM_CH*MULT_W-1:0] mult_pl,
    output logic [NUM_CH*MULT_W-1:0] mult_dl,
    output logic [NUM_CH*TYPE_W-1:0] type_start,
    output logic                     cfg_upd,
    output logic                     pc_start,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam logic [8:0] MAP_END = ch_base(NUM_CH);

    cfg_state_t state;
    cfg_state_t state_nxt;
    logic       start_req;
    logic       cmd_wr;
    logic       is_apply;
    logic       clr_err;
    logic       accept;
    logic       apply_now;
    logic       cfg_upd_nxt;
    logic       pc_start_nxt;
    logic [1:0] err_set;
    logic [7:0] rd_bytes [NUM_CH];
    logic [7:0] rd_mux;

    assign cmd_wr     = wr_en && (wr_addr == 8'h00);
    assign is_apply   = cmd_wr && ((wr_data == CMD_APPLY_START) || (wr_data == CMD_APPLY));
    assign clr_err    = cmd_wr && (wr_data == CMD_CLR_ERR);
    assign accept     = is_apply && (state == IDLE);
    assign apply_now  = (state == APPLY);
    assign busy       = (state != IDLE);
    assign err_set[0] = wr_en && ({1'b0, wr_addr} >= MAP_END);
    // Any command that is neither a clear nor an accepted apply is unknown or dropped.
    assign err_set[1] = cmd_wr && !clr_err && !accept;

    always_comb begin
        state_nxt    = state;
        cfg_upd_nxt  = 1'b0;
        pc_start_nxt = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = APPLY;
            APPLY: begin
                cfg_upd_nxt = 1'b1;
                state_nxt   = start_req ? START : IDLE;
            end
            START: begin
                pc_start_nxt = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_RAM or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            start_req <= 1'b0;
            cfg_upd   <= 1'b0;
            pc_start  <= 1'b0;
            err       <= '0;
            rd_data   <= '0;
        end else begin
            state    <= state_nxt;
            cfg_upd  <= cfg_upd_nxt;
            pc_start <= pc_start_nxt;
            if (accept) start_req <= (wr_data == CMD_APPLY_START);
            if (clr_err) err <= '0;
            else         err <= err | err_set;
            rd_data <= (rd_addr == 8'h00) ? {6'b0, state} : rd_mux;
        end
    end

    // Slots drive zero outside their window, so an OR is enough to merge readback.
    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < NUM_CH; n++) rd_mux |= rd_bytes[n];
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        chan_cfg_slot #(
            .CH     (n),
            .MULT_W (MULT_W),
            .TYPE_W (TYPE_W)
        ) u_slot (
            .clk_RAM    (clk_RAM),
            .rst_n      (rst_n),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .rd_addr    (rd_addr),
            .apply      (apply_now),
            .rd_byte    (rd_bytes[n]),
            .pl_drt     (pl_drt[16*n +: 16]),
            .dl_del     (dl_del[16*n +: 16]),
            .mult_pl    (mult_pl[MULT_W*n +: MULT_W]),
            .mult_dl    (mult_dl[MULT_W*n +: MULT_W]),
            .type_start (type_start[TYPE_W*n +: TYPE_W])
        );
    end

endmodule

// File: tb/tb_chan_cfg_bank.sv
// Self-checking bench for chan_cfg_bank: write/readback vector table, readback
// scoreboard queue, and hand-written apply/start/error/reset sequences.
module tb_chan_cfg_bank;

    localparam int NUM_CH = 16;
    localparam int MULT_W = 5;
    localparam int TYPE_W = 4;

    logic                     clk_RAM = 1'b0;
    logic                     rst_n   = 1'b0;
    logic                     wr_en   = 1'b0;
    logic [7:0]               wr_addr = '0;
    logic [7:0]               wr_data = '0;
    logic [7:0]               rd_addr = '0;
    logic [7:0]               rd_data;
    logic [NUM_CH*16-1:0]     pl_drt;
    logic [NUM_CH*16-1:0]     dl_del;
    logic [NUM_CH*MULT_W-1:0] mult_pl;
    logic [NUM_CH*MULT_W-1:0] mult_dl;
    logic [NUM_CH*TYPE_W-1:0] type_start;
    logic                     cfg_upd;
    logic                     pc_start;
    logic                     busy;
    logic [1:0]               err;

    chan_cfg_bank #(
        .NUM_CH (NUM_CH),
        .MULT_W (MULT_W),
        .TYPE_W (TYPE_W)
    ) dut (
        .clk_RAM    (clk_RAM),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pl_drt     (pl_drt),
        .dl_del     (dl_del),
        .mult_pl    (mult_pl),
        .mult_dl    (mult_dl),
        .type_start (type_start),
        .cfg_upd    (cfg_upd),
        .pc_start   (pc_start),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_RAM = ~clk_RAM;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd_exp;
    } wr_vec_t;

    wr_vec_t    vecs[$];
    logic [7:0] rd_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk_RAM);
        wr_en = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        @(negedge clk_RAM);
    endtask

    // Readback through the scoreboard: expectation queued when rd_addr is driven.
    task automatic readback(input string name, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        rd_q.push_back(exp);
        idle();
        check(name, 32'(rd_data), 32'(rd_q.pop_front()));
    endtask

    function automatic logic [15:0] pl_of(input int ch);
        return pl_drt[16*ch +: 16];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       exp_busy [4];
        logic       exp_pc   [4];
        logic       exp_cfg  [4];
        logic [15:0] exp_pl  [4];
        int         pc_cnt;
        int         busy_cnt;

        vecs.push_back('{8'd1,  8'h12, 8'h12});
        vecs.push_back('{8'd2,  8'h34, 8'h34});
        vecs.push_back('{8'd3,  8'h07, 8'h07});
        vecs.push_back('{8'd4,  8'h00, 8'h00});
        vecs.push_back('{8'd5,  8'h10, 8'h10});
        vecs.push_back('{8'd6,  8'h03, 8'h03});
        vecs.push_back('{8'd7,  8'h02, 8'h02});
        vecs.push_back('{8'd10, 8'hFF, 8'h1F});   // ch1 mult_pl truncated to 5 bits
        vecs.push_back('{8'd14, 8'hFF, 8'h0F});   // ch1 type_start truncated to 4 bits

        // Reset state
        repeat (2) @(negedge clk_RAM);
        check("rst_pl_all_zero", 32'(pl_drt == '0), 32'd1);
        check("rst_busy",        32'(busy),         32'd0);
        check("rst_err",         32'(err),          32'd0);
        check("rst_pc_start",    32'(pc_start),     32'd0);
        check("rst_rd_data",     32'(rd_data),      32'd0);
        rst_n = 1'b1;
        idle();

        // Table: write each byte, read it back through the scoreboard
        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].data);
            readback($sformatf("rdbk_addr%0d", vecs[i].addr), vecs[i].addr, vecs[i].rd_exp);
        end

        // APPLY only: active loads after t+1, no start pulse
        drive(8'h00, 8'hA5);
        check("a5_busy_t",   32'(busy),    32'd1);
        check("a5_cfg_t",    32'(cfg_upd), 32'd0);
        check("a5_pl_not_yet", 32'(pl_of(0)), 32'h0000);
        rd_addr = 8'h00;
        rd_q.push_back(8'h01);                  // state APPLY sampled at t+1
        idle();
        check("a5_rd_state", 32'(rd_data), 32'(rd_q.pop_front()));
        check("a5_cfg_t1",   32'(cfg_upd), 32'd1);
        check("a5_pl0",      32'(pl_of(0)), 32'h1234);
        check("a5_mpl0",     32'(mult_pl[4:0]), 32'h07);
        check("a5_dl0",      32'(dl_del[15:0]), 32'h0010);
        check("a5_mdl0",     32'(mult_dl[4:0]), 32'h03);
        check("a5_type0",    32'(type_start[3:0]), 32'h2);
        check("a5_mpl1_trunc",  32'(mult_pl[9:5]), 32'h1F);
        check("a5_type1_trunc", 32'(type_start[7:4]), 32'hF);
        check("a5_busy_t1",  32'(busy),     32'd0);
        check("a5_pc_t1",    32'(pc_start), 32'd0);
        idle();
        check("a5_cfg_t2",   32'(cfg_upd),  32'd0);
        check("a5_pc_t2",    32'(pc_start), 32'd0);

        // APPLY+START on ch15
        drive(8'd106, 8'hBE);
        drive(8'd107, 8'hEF);
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0};
        exp_cfg  = '{1'b0, 1'b1, 1'b0, 1'b0};
        exp_pc   = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_pl   = '{16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        pc_cnt   = 0;
        busy_cnt = 0;
        drive(8'h00, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ff_busy_%0d", i), 32'(busy),     32'(exp_busy[i]));
            check($sformatf("ff_cfg_%0d", i),  32'(cfg_upd),  32'(exp_cfg[i]));
            check($sformatf("ff_pc_%0d", i),   32'(pc_start), 32'(exp_pc[i]));
            check($sformatf("ff_pl15_%0d", i), 32'(pl_of(15)), 32'(exp_pl[i]));
            pc_cnt   += int'(pc_start);
            busy_cnt += int'(busy);
            if (i < 3) idle();
        end
        check("ff_pc_count",   32'(pc_cnt),   32'd1);
        check("ff_busy_count", 32'(busy_cnt), 32'd2);

        // ch3 PL low byte written on the APPLY copy edge
        drive(8'd22, 8'h11);
        drive(8'd23, 8'h00);
        drive(8'h00, 8'hA5);
        drive(8'd23, 8'h77);
        check("race_cfg",    32'(cfg_upd), 32'd1);
        check("race_pl3_old", 32'(pl_of(3)), 32'h1100);
        readback("race_rdbk23", 8'd23, 8'h77);
        drive(8'h00, 8'hA5);
        idle();
        check("race_pl3_new", 32'(pl_of(3)), 32'h1177);

        // Unmapped write and unknown command
        drive(8'(1 + 7 * NUM_CH), 8'h99);
        check("unmap_err", 32'(err), 32'h1);
        readback("unmap_rdbk", 8'(1 + 7 * NUM_CH), 8'h00);
        drive(8'h00, 8'h33);
        check("unk_err",  32'(err),  32'h3);
        check("unk_busy", 32'(busy), 32'd0);
        check("unk_pl0",  32'(pl_of(0)), 32'h1234);
        drive(8'h00, 8'h5A);
        check("clr_err", 32'(err), 32'h0);

        // Second APPLY+START while busy is dropped
        pc_cnt = 0;
        drive(8'h00, 8'hFF);
        drive(8'h00, 8'hFF);
        pc_cnt += int'(pc_start);
        for (int i = 0; i < 4; i++) begin
            idle();
            pc_cnt += int'(pc_start);
        end
        check("drop_pc_count", 32'(pc_cnt), 32'd1);
        check("drop_err",      32'(err),    32'h2);

        // Reset between t+1 and t+2 of an APPLY+START
        drive(8'h00, 8'hFF);
        idle();
        check("abort_cfg_before", 32'(cfg_upd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_pc",     32'(pc_start),     32'd0);
        check("abort_busy",   32'(busy),         32'd0);
        check("abort_cfg",    32'(cfg_upd),      32'd0);
        check("abort_err",    32'(err),          32'd0);
        check("abort_rd",     32'(rd_data),      32'd0);
        check("abort_pl",     32'(pl_drt == '0), 32'd1);
        check("abort_active_rest", 32'((dl_del == '0) && (mult_pl == '0) && (mult_dl == '0) && (type_start == '0)), 32'd1);
        pc_cnt = 0;
        @(negedge clk_RAM);
        pc_cnt += int'(pc_start);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            pc_cnt += int'(pc_start);
        end
        check("abort_pc_count", 32'(pc_cnt), 32'd0);
        readback("abort_shadow", 8'd1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
